// File: rtl/sp_bram_arbiter.sv
// Round-robin arbiter sharing one single-port, write-first block RAM between
// NUM_REQ requesters. Byte-masked writes become read-modify-write sequences,
// and the array is zero-filled after reset before any request is accepted.
module sp_bram_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SETS   = 1024,
  parameter int unsigned NUM_REQ    = 2,
  localparam int unsigned AW        = $clog2(NUM_SETS),
  localparam int unsigned BW        = DATA_WIDTH / 8,
  localparam int unsigned RRW       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*AW-1:0]         req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_REQ*BW-1:0]         req_wmask_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic                          init_done_o,
  output logic                          bram_en_o,
  output logic                          bram_we_o,
  output logic [AW-1:0]                 bram_addr_o,
  output logic [DATA_WIDTH-1:0]         bram_wdata_o,
  input  logic [DATA_WIDTH-1:0]         bram_rdata_i
);

  typedef enum logic [1:0] {StInit, StIdle, StRmwWr, StRsp} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [RRW-1:0]        rr_q, rr_d;
  logic [RRW-1:0]        owner_q, owner_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BW-1:0]         mask_q, mask_d;
  logic                  init_done_q, init_done_d;

  logic                  gnt_found;
  logic [RRW-1:0]        gnt_idx;
  logic                  sel_we;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BW-1:0]         sel_mask;
  logic [DATA_WIDTH-1:0] merged;

  logic [NUM_REQ-1:0]    ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  ram_en;
  logic                  ram_we;

  // Round-robin search: first valid index at or above rr_q, wrapping.
  always_comb begin
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(rr_q) + i) % NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!gnt_found && (j == cand) && req_valid_i[j]) begin
          gnt_found = 1'b1;
          gnt_idx   = RRW'(j);
        end
      end
    end
  end

  // Mux the granted requester's payload.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (gnt_idx == RRW'(j)) begin
        sel_we    = req_we_i[j];
        sel_addr  = req_addr_i[j*AW +: AW];
        sel_wdata = req_wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
        sel_mask  = req_wmask_i[j*BW +: BW];
      end
    end
  end

  // Byte merge of the old RAM word with the latched write data.
  always_comb begin
    merged = bram_rdata_i;
    for (int unsigned k = 0; k < BW; k++) begin
      if (mask_q[k]) merged[k*8 +: 8] = wdata_q[k*8 +: 8];
    end
  end

  // Next-state and output logic of the controller FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    init_done_d  = init_done_q;
    ready        = '0;
    rsp_valid    = '0;
    rsp_rdata    = '0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    unique case (state_q)
      StInit: begin
        ram_en      = 1'b1;
        ram_we      = 1'b1;
        bram_addr_o = cnt_q;
        cnt_d       = cnt_q + AW'(1);
        if (cnt_q == AW'(NUM_SETS - 1)) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
        if (gnt_found) begin
          for (int unsigned j = 0; j < NUM_REQ; j++) ready[j] = (gnt_idx == RRW'(j));
          ram_en      = 1'b1;
          bram_addr_o = sel_addr;
          owner_d     = gnt_idx;
          rr_d        = (gnt_idx == RRW'(NUM_REQ - 1)) ? '0 : gnt_idx + RRW'(1);
          if (sel_we && (&sel_mask)) begin
            ram_we       = 1'b1;
            bram_wdata_o = sel_wdata;
            state_d      = StRsp;
          end else if (sel_we) begin
            // Partial write: read the old word now, merge and write next cycle.
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            mask_d  = sel_mask;
            state_d = StRmwWr;
          end else begin
            state_d = StRsp;
          end
        end
      end
      StRmwWr: begin
        ram_en       = 1'b1;
        ram_we       = 1'b1;
        bram_addr_o  = addr_q;
        bram_wdata_o = merged;
        state_d      = StRsp;
      end
      StRsp: begin
        for (int unsigned j = 0; j < NUM_REQ; j++) rsp_valid[j] = (owner_q == RRW'(j));
        // Write-first RAM: this is the written word after a write.
        rsp_rdata = bram_rdata_i;
        state_d   = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  // Reset-held cycles must not touch the RAM or handshake with anyone.
  always_comb begin
    req_ready_o = ready & {NUM_REQ{rst_ni}};
    rsp_valid_o = rsp_valid & {NUM_REQ{rst_ni}};
    rsp_rdata_o = rsp_rdata & {DATA_WIDTH{rst_ni}};
    bram_en_o   = ram_en & rst_ni;
    bram_we_o   = ram_we & rst_ni;
    init_done_o = init_done_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      rr_q        <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      init_done_q <= init_done_d;
    end
  end

endmodule
